// File: rtl/eth_measurer_ctl.sv
// Periodic ping controller: launches numbered pings, measures echo round-trip time,
// and flags pings whose echo does not arrive within the timeout window.
module eth_measurer_ctl #(
    parameter int TIME_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [TIME_W-1:0] period,
    input  logic [TIME_W-1:0] timeout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [63:0]       tx_ping_id,
    input  logic [63:0]       rx_ping_id,
    output logic [TIME_W-1:0] rtt,
    output logic              rtt_valid,
    output logic              lost,
    output logic [63:0]       ping_count,
    output logic [63:0]       lost_count,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, HOLD} state_t;

    state_t            state_reg;
    logic [TIME_W-1:0] elapsed_reg;
    logic [63:0]       ping_id_reg;
    logic              tx_valid_reg;
    logic [TIME_W-1:0] rtt_reg;
    logic              rtt_valid_reg;
    logic              lost_reg;
    logic [63:0]       ping_count_reg;
    logic [63:0]       lost_count_reg;
    logic              busy_reg;

    logic [TIME_W-1:0] elapsed_next;
    logic [63:0]       ping_id_next;
    logic              echo_match;
    logic              timed_out;
    logic              launch_ok;

    assign elapsed_next = (elapsed_reg == '1) ? elapsed_reg : elapsed_reg + 1'b1;
    // The all-ones id is what the RX path reports after its reset, so it is never issued.
    assign ping_id_next = (ping_id_reg == 64'hFFFF_FFFF_FFFF_FFFE) ? 64'd0
                                                                   : ping_id_reg + 64'd1;
    assign echo_match   = (rx_ping_id == ping_id_reg);
    assign timed_out    = (timeout != '0) && (elapsed_reg >= timeout);
    assign launch_ok    = enable && (period != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            elapsed_reg    <= '0;
            ping_id_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            rtt_reg        <= '0;
            rtt_valid_reg  <= 1'b0;
            lost_reg       <= 1'b0;
            ping_count_reg <= '0;
            lost_count_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            rtt_valid_reg <= 1'b0;
            lost_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch_ok) begin
                        state_reg    <= SEND;
                        tx_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                SEND: begin
                    // Request is held until accepted regardless of enable.
                    if (tx_ready) begin
                        state_reg      <= WAIT_RX;
                        tx_valid_reg   <= 1'b0;
                        elapsed_reg    <= {{(TIME_W-1){1'b0}}, 1'b1};
                        ping_count_reg <= ping_count_reg + 64'd1;
                    end
                end
                WAIT_RX: begin
                    elapsed_reg <= elapsed_next;
                    if (echo_match) begin
                        rtt_reg       <= elapsed_reg;
                        rtt_valid_reg <= 1'b1;
                        ping_id_reg   <= ping_id_next;
                        state_reg     <= HOLD;
                    end else if (timed_out) begin
                        lost_reg       <= 1'b1;
                        lost_count_reg <= lost_count_reg + 64'd1;
                        ping_id_reg    <= ping_id_next;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    elapsed_reg <= elapsed_next;
                    if (elapsed_reg >= period) begin
                        if (launch_ok) begin
                            state_reg    <= SEND;
                            tx_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_valid   = tx_valid_reg;
    assign tx_ping_id = ping_id_reg;
    assign rtt        = rtt_reg;
    assign rtt_valid  = rtt_valid_reg;
    assign lost       = lost_reg;
    assign ping_count = ping_count_reg;
    assign lost_count = lost_count_reg;
    assign busy       = busy_reg;

endmodule
